// File: rtl/oisc8_pkg.sv
// OISC8 shared definitions: instruction address field width and the
// bit positions of the buffered-port status word.
package oisc8_pkg;

  // Width of the instruction src/dst address fields.
  localparam int ASIZE = 8;

  // Status word bit positions (word is zero-extended to the bus width).
  localparam int PST_RX_EMPTY = 0;
  localparam int PST_RX_FULL  = 1;
  localparam int PST_TX_EMPTY = 2;
  localparam int PST_TX_FULL  = 3;
  localparam int PST_RX_OVF   = 4;
  localparam int PST_TX_UNF   = 5;

endpackage

// File: rtl/oisc_sync_fifo.sv
// Single-clock FIFO used for both directions of the buffered bus port.
// A push into a full FIFO is still taken when a pop happens at the same
// edge, so the occupancy never exceeds DEPTH and never drops below zero.
// The head reads as zero while the FIFO is empty.
module oisc_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_data,
  output logic [DW-1:0]            o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_push_ok,
  output logic                     o_pop_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Pop only what exists; push when there is room or a slot frees this edge.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_push_ok = w_push;
  assign o_pop_ok  = w_pop;

  // Head comes from storage; gated so an empty FIFO presents zero.
  assign o_head = o_empty ? '0 : r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is gated.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/oisc_port_fifo.sv
// Buffered OISC8 move-bus port: bus writes (register or immediate) land
// in an RX FIFO for a peripheral, peripheral data queues in a TX FIFO for
// bus reads. Build option OISC_PORT_FIFO_STATUS_EN adds a status source
// address and sticky overflow/underflow flags; without it those flags
// read 0 and drops/underflows happen silently.
module oisc_port_fifo
  import oisc8_pkg::*;
#(
  parameter int               DW        = 8,
  parameter int               DEPTH     = 4,
  parameter logic [ASIZE-1:0] ADDR      = 8'd0,
  parameter logic [ASIZE-1:0] ADDRI     = 8'd0,
  parameter logic [ASIZE-1:0] ADDR_STAT = 8'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [DW-1:0]          bus_data,
  input  logic [ASIZE-1:0]       instr_dst,
  input  logic [ASIZE-1:0]       instr_src,
  output logic [DW-1:0]          rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic [DW-1:0]          tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   rx_ovf,
  output logic                   tx_unf
);

`ifdef OISC_PORT_FIFO_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  // Address decode
  logic w_rd, w_rdi, w_wr, w_ws;
  // RX side
  logic [DW-1:0] w_imm, w_rx_wdata;
  logic          w_rx_push, w_rx_full, w_rx_empty, w_rx_push_ok, w_rx_pop_ok;
  // TX side
  logic [DW-1:0] w_tx_head;
  logic          w_tx_full, w_tx_empty, w_tx_push_ok, w_tx_pop_ok;
  // Bus drive and flags
  logic [DW-1:0] w_stat, w_bus_out;
  logic          w_drv, w_ovf_evt, w_unf_evt;
  logic          r_rx_ovf, r_tx_unf;

  // Register destination beats immediate destination on a collision;
  // a TX read beats a status read on the source side.
  assign w_rd  = (instr_dst == ADDR);
  assign w_rdi = !w_rd && (instr_dst == ADDRI);
  assign w_wr  = (instr_src == ADDR);
  assign w_ws  = STAT_EN && !w_wr && (instr_src == ADDR_STAT);

  // Immediate zero-extended to the bus width.
  always_comb begin
    w_imm = '0;
    w_imm[ASIZE-1:0] = instr_src;
  end

  // On loopback (rd with wr) bus_data carries our own TX head.
  assign w_rx_wdata = w_rd ? bus_data : w_imm;
  assign w_rx_push  = w_rd || w_rdi;

  oisc_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_rx_push),
    .i_pop     (rx_ready),
    .i_data    (w_rx_wdata),
    .o_head    (rx_data),
    .o_full    (w_rx_full),
    .o_empty   (w_rx_empty),
    .o_count   (rx_count),
    .o_push_ok (w_rx_push_ok),
    .o_pop_ok  (w_rx_pop_ok)
  );

  // A peripheral push on a full TX is still taken when the bus pops at
  // the same edge; tx_ready itself stays a pure function of occupancy.
  oisc_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .i_push    (tx_valid),
    .i_pop     (w_wr),
    .i_data    (tx_data),
    .o_head    (w_tx_head),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty),
    .o_count   (tx_count),
    .o_push_ok (w_tx_push_ok),
    .o_pop_ok  (w_tx_pop_ok)
  );

  assign rx_valid = !w_rx_empty;
  assign tx_ready = !w_tx_full;

  // Status word assembly; upper bits stay zero.
  always_comb begin
    w_stat = '0;
    w_stat[PST_RX_EMPTY] = w_rx_empty;
    w_stat[PST_RX_FULL]  = w_rx_full;
    w_stat[PST_TX_EMPTY] = w_tx_empty;
    w_stat[PST_TX_FULL]  = w_tx_full;
    w_stat[PST_RX_OVF]   = r_rx_ovf;
    w_stat[PST_TX_UNF]   = r_tx_unf;
  end

  // Empty TX reads as zero because the FIFO head is gated when empty.
  assign w_bus_out = w_wr ? w_tx_head : w_stat;
  assign w_drv     = !rst && (w_wr || w_ws);
  assign bus_data  = w_drv ? w_bus_out : {DW{1'bz}};

  // Error events: a bus push the RX could not take, a read of empty TX.
  assign w_ovf_evt = w_rx_push && !w_rx_push_ok;
  assign w_unf_evt = w_wr && w_tx_empty;

  // Sticky flags: cleared by a status read unless a new event lands at
  // the same edge; held at zero when the status feature is compiled out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ovf <= 1'b0;
      r_tx_unf <= 1'b0;
    end else begin
      r_rx_ovf <= STAT_EN && ((r_rx_ovf && !w_ws) || w_ovf_evt);
      r_tx_unf <= STAT_EN && ((r_tx_unf && !w_ws) || w_unf_evt);
    end
  end

  assign rx_ovf = r_rx_ovf;
  assign tx_unf = r_tx_unf;

  // Handshake results not needed beyond the flag logic above.
  logic w_unused;
  assign w_unused = w_rx_pop_ok ^ w_tx_push_ok ^ w_tx_pop_ok;

endmodule

// File: tb/tb_oisc_port_fifo.sv
// Scoreboard bench for oisc_port_fifo: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_oisc_port_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] A_REG  = 8'h10;
  localparam logic [7:0] A_IMM  = 8'h11;
  localparam logic [7:0] A_STAT = 8'h12;
  localparam logic [7:0] A_IDLE = 8'hFF;
`ifdef OISC_PORT_FIFO_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [DW-1:0] bus_data;
  logic [7:0] instr_dst = A_IDLE, instr_src = A_IDLE;
  logic [DW-1:0] rx_data, tx_data = '0;
  logic rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready;
  logic [AW:0] rx_count, tx_count;
  logic rx_ovf, tx_unf;
  logic tb_drv = 1'b0;
  logic [DW-1:0] tb_bus = '0;

  assign bus_data = tb_drv ? tb_bus : {DW{1'bz}};

  oisc_port_fifo #(.DW(DW), .DEPTH(DEPTH), .ADDR(A_REG), .ADDRI(A_IMM),
                   .ADDR_STAT(A_STAT)) dut (
    .clk(clk), .rst(rst), .bus_data(bus_data),
    .instr_dst(instr_dst), .instr_src(instr_src),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_count(rx_count), .tx_count(tx_count),
    .rx_ovf(rx_ovf), .tx_unf(tx_unf)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queues plus two flags.
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  bit m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    int rxc; int txc; bit rxv; bit txr; bit ovf; bit unf; logic [DW-1:0] rxd;
  } st_t;
  st_t st_q[$];
  logic [DW-1:0] bus_q[$];
  logic [DW-1:0] pop_q[$];

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (st_q.size() > 0) begin
        st_t e;
        e = st_q.pop_front();
        chk("rx_count", 32'(rx_count), 32'(e.rxc));
        chk("tx_count", 32'(tx_count), 32'(e.txc));
        chk("rx_valid", 32'(rx_valid), 32'(e.rxv));
        chk("tx_ready", 32'(tx_ready), 32'(e.txr));
        chk("rx_ovf", 32'(rx_ovf), 32'(e.ovf));
        chk("tx_unf", 32'(tx_unf), 32'(e.unf));
        if (e.rxv) chk("rx_head", 32'(rx_data), 32'(e.rxd));
      end
      if (instr_src == A_REG) begin
        if (bus_q.size() > 0) chk("bus_read", 32'(bus_data), 32'(bus_q.pop_front()));
        else chk("bus_read_unexpected", 32'(1), 32'(0));
      end
      if (rx_valid && rx_ready) begin
        if (pop_q.size() > 0) chk("rx_pop", 32'(rx_data), 32'(pop_q.pop_front()));
        else chk("rx_pop_unexpected", 32'(1), 32'(0));
      end
    end
  end

  // One bus cycle: drive inputs, queue expectations from the model,
  // advance the model across the coming edge, then wait for that edge.
  task automatic cyc(input logic [7:0] dst, input logic [7:0] src, input logic [DW-1:0] bv,
                     input bit rr, input bit tv, input logic [DW-1:0] td);
    bit rd, rdi, wr, ws, rxpop, txpop, txpush, ovf_e, unf_e;
    logic [DW-1:0] stat, busv, pv;
    st_t e;
    instr_dst = dst; instr_src = src; rx_ready = rr; tx_valid = tv; tx_data = td;
    rd  = (dst == A_REG);
    rdi = !rd && (dst == A_IMM);
    wr  = (src == A_REG);
    ws  = STAT && !wr && (src == A_STAT);
    stat = '0;
    stat[0] = (rxq.size() == 0);
    stat[1] = (rxq.size() == DEPTH);
    stat[2] = (txq.size() == 0);
    stat[3] = (txq.size() == DEPTH);
    stat[4] = m_ovf;
    stat[5] = m_unf;
    busv = wr ? ((txq.size() > 0) ? txq[0] : '0) : (ws ? stat : bv);
    tb_drv = rd && !wr && !ws;
    tb_bus = bv;
    e.rxc = rxq.size(); e.txc = txq.size();
    e.rxv = (rxq.size() > 0); e.txr = (txq.size() < DEPTH);
    e.ovf = m_ovf; e.unf = m_unf;
    e.rxd = (rxq.size() > 0) ? rxq[0] : '0;
    st_q.push_back(e);
    if (wr) bus_q.push_back(busv);
    rxpop  = rr && (rxq.size() > 0);
    txpop  = wr && (txq.size() > 0);
    txpush = tv && ((txq.size() < DEPTH) || txpop);
    unf_e  = wr && (txq.size() == 0);
    ovf_e  = 1'b0;
    pv = '0;
    pv[7:0] = src;
    if (rd) pv = busv;
    if (rxpop) pop_q.push_back(rxq[0]);
    if ((rd || rdi) && !(rxq.size() < DEPTH || rxpop)) ovf_e = 1'b1;
    if (rxpop) void'(rxq.pop_front());
    if ((rd || rdi) && !ovf_e) rxq.push_back(pv);
    if (txpop) void'(txq.pop_front());
    if (txpush) txq.push_back(td);
    m_ovf = STAT && ((m_ovf && !ws) || ovf_e);
    m_unf = STAT && ((m_unf && !ws) || unf_e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rr);
    cyc(A_IDLE, A_IDLE, '0, rr, 1'b0, '0);
  endtask

  // Asynchronous reset pulse between edges, checked before the next edge.
  task automatic async_reset();
    instr_dst = A_IDLE; instr_src = A_IDLE; rx_ready = 1'b0; tx_valid = 1'b0; tb_drv = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_rx_count", 32'(rx_count), 32'(0));
    chk("rst_tx_count", 32'(tx_count), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_ovf", 32'(rx_ovf), 32'(0));
    chk("rst_tx_unf", 32'(tx_unf), 32'(0));
    rst = 1'b0;
    rxq.delete(); txq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Power-on reset state.
    #2;
    chk("por_rx_count", 32'(rx_count), 32'(0));
    chk("por_rx_valid", 32'(rx_valid), 32'(0));
    chk("por_tx_ready", 32'(tx_ready), 32'(1));
    chk("por_rx_data", 32'(rx_data), 32'(0));
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Register writes queue in order, then drain.
    cyc(A_REG, A_IDLE, 16'h0011, 0, 0, '0);
    cyc(A_REG, A_IDLE, 16'h0022, 0, 0, '0);
    idle(1); idle(1); idle(0);

    // Immediate write is zero-extended.
    cyc(A_IMM, 8'h5A, '0, 0, 0, '0);
    idle(1); idle(0);

    // Overflow on the fifth write, then two status reads.
    for (int i = 1; i <= 5; i++) cyc(A_REG, A_IDLE, DW'(i), 0, 0, '0);
    cyc(A_IDLE, A_STAT, '0, 0, 0, '0);
    cyc(A_IDLE, A_STAT, '0, 0, 0, '0);
    idle(0);
    for (int i = 0; i < 4; i++) idle(1);

    // Peripheral pushes, bus reads, then underflow read.
    cyc(A_IDLE, A_IDLE, '0, 0, 1, 16'h00A5);
    cyc(A_IDLE, A_IDLE, '0, 0, 1, 16'h003C);
    cyc(A_IDLE, A_REG, '0, 0, 0, '0);
    cyc(A_IDLE, A_REG, '0, 0, 0, '0);
    cyc(A_IDLE, A_REG, '0, 0, 0, '0);
    cyc(A_IDLE, A_STAT, '0, 0, 0, '0);
    idle(0);

    // Loopback: TX head captured by RX at the same edge.
    cyc(A_IDLE, A_IDLE, '0, 0, 1, 16'h0077);
    cyc(A_REG, A_REG, '0, 0, 0, '0);
    idle(1); idle(0);

    // Full TX: peripheral push and bus pop together.
    for (int i = 0; i < 4; i++) cyc(A_IDLE, A_IDLE, '0, 0, 1, DW'(16'h0100 + i));
    cyc(A_IDLE, A_REG, '0, 0, 1, 16'h0200);
    for (int i = 0; i < 5; i++) cyc(A_IDLE, A_REG, '0, 0, 0, '0);

    // Async reset mid-burst.
    for (int i = 0; i < 3; i++) cyc(A_REG, A_IDLE, DW'(16'h0030 + i), 0, 0, '0);
    for (int i = 0; i < 2; i++) cyc(A_IDLE, A_IDLE, '0, 0, 1, DW'(16'h0040 + i));
    async_reset();
    idle(0);

    // Randomized traffic with varying pop/push pressure.
    for (int n = 0; n < 800; n++) begin
      logic [7:0] d, s;
      bit rr, tv;
      int ph;
      ph = (n / 100) % 3;
      case ($urandom_range(0, 3))
        0: d = A_REG; 1: d = A_IMM; default: d = A_IDLE;
      endcase
      case ($urandom_range(0, 4))
        0: s = A_REG; 1: s = A_STAT; 2: s = 8'($urandom); default: s = A_IDLE;
      endcase
      rr = (ph == 0) ? ($urandom_range(0, 7) == 0) : (ph == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      tv = (ph == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      cyc(d, s, DW'($urandom), rr, tv, DW'($urandom));
    end
    idle(0); idle(0);

    chk("bus_q_drained", 32'(bus_q.size()), 32'(0));
    chk("pop_q_drained", 32'(pop_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
